multicycle_ctrl: RTL and testbench

Moore/Mealy control FSM sequencing the multi-cycle MIPS datapath (PC, IR, register file, sign extender, ALU, unified memory) one instruction at a time. It decodes the latched opcode, drives every mux select and write enable (including the sign/zero-extend select), and handshakes with a memory that may insert wait states. It sits beside the datapath top level and replaces the single-cycle decoder.

---
 rtl/multicycle_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_dec.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes,
// datapath mux selects and the packed control word driven by the FSM.
package multicycle_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_WB_MEM = 4'd4;
    localparam logic [3:0] S_MEM_WR = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_EXEC_I = 4'd7;
    localparam logic [3:0] S_WB_ALU = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OP_IMM    = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    // Quiet control word: nothing written, immediates sign-extended.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.ext_op = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Opcode classifier for the multi-cycle controller. andi/ori are recognised
// only when MULTICYCLE_CTRL_LOGIC_IMM_EN is defined; otherwise they are illegal.
module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic       rtype_o,
    output logic       mem_ld_o,
    output logic       mem_st_o,
    output logic       branch_o,
    output logic       alu_imm_o,
    output logic       logic_imm_o,
    output logic       jump_o,
    output logic       illegal_o
);

    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rtype_o     = 1'b0;
        mem_ld_o    = 1'b0;
        mem_st_o    = 1'b0;
        branch_o    = 1'b0;
        alu_imm_o   = 1'b0;
        logic_imm_o = 1'b0;
        jump_o      = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OP_RTYPE:        rtype_o     = 1'b1;
            OP_LW:           mem_ld_o    = 1'b1;
            OP_SW:           mem_st_o    = 1'b1;
            OP_BEQ, OP_BNE:  branch_o    = 1'b1;
            OP_ADDI, OP_SLTI: alu_imm_o  = 1'b1;
`ifdef MULTICYCLE_CTRL_LOGIC_IMM_EN
            OP_ANDI, OP_ORI: logic_imm_o = 1'b1;
`endif
            OP_J:            jump_o      = 1'b1;
            default:         illegal_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath with wait-state memory handshake.
// Optional MULTICYCLE_CTRL_LOGIC_IMM_EN enables zero-extended andi/ori.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       ext_op_o,
    output logic       reg_we_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;

    logic is_rtype, is_ld, is_st, is_branch, is_alu_imm, is_logic_imm, is_jump, is_illegal;

    multicycle_ctrl_dec u_dec (
        .opcode_i    (opcode_i),
        .rtype_o     (is_rtype),
        .mem_ld_o    (is_ld),
        .mem_st_o    (is_st),
        .branch_o    (is_branch),
        .alu_imm_o   (is_alu_imm),
        .logic_imm_o (is_logic_imm),
        .jump_o      (is_jump),
        .illegal_o   (is_illegal)
    );

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        ctrl    = ctrl_idle();
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.ir_we     = mem_ack_i;
                ctrl.pc_we     = mem_ack_i;
                if (mem_ack_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ctrl.alu_src_b = ALU_B_IMM_SH2;
                if (is_rtype)                       state_d = S_EXEC_R;
                else if (is_ld || is_st)            state_d = S_ADDR;
                else if (is_branch)                 state_d = S_BRANCH;
                else if (is_alu_imm || is_logic_imm) state_d = S_EXEC_I;
                else if (is_jump)                   state_d = S_JUMP;
                else begin
                    ctrl.illegal = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                state_d        = is_ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ack_i) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ack_i) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_RT;
                ctrl.alu_op    = ALU_OP_FUNCT;
                state_d        = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_IMM;
                ctrl.ext_op    = !is_logic_imm;
                state_d        = S_WB_ALU;
            end
            S_WB_ALU: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = is_rtype;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_RT;
                ctrl.alu_op    = ALU_OP_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.pc_we     = zero_i ^ (opcode_i == OP_BNE);
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src = PC_SRC_JUMP;
                ctrl.pc_we  = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs read all-zero while reset is held, even though FETCH would
    // otherwise already be requesting memory.
    assign ctrl_out = rst_n_i ? ctrl : '0;

    assign mem_req_o    = ctrl_out.mem_req;
    assign mem_we_o     = ctrl_out.mem_we;
    assign iord_o       = ctrl_out.iord;
    assign ir_we_o      = ctrl_out.ir_we;
    assign pc_we_o      = ctrl_out.pc_we;
    assign pc_src_o     = ctrl_out.pc_src;
    assign alu_src_a_o  = ctrl_out.alu_src_a;
    assign alu_src_b_o  = ctrl_out.alu_src_b;
    assign alu_op_o     = ctrl_out.alu_op;
    assign ext_op_o     = ctrl_out.ext_op;
    assign reg_we_o     = ctrl_out.reg_we;
    assign reg_dst_o    = ctrl_out.reg_dst;
    assign mem_to_reg_o = ctrl_out.mem_to_reg;
    assign illegal_o    = ctrl_out.illegal;
    assign state_o      = rst_n_i ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the hand-computed
// per-cycle control vector, a negedge monitor pops and compares it.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [5:0] opcode_i = 6'h00;
    logic       zero_i = 1'b0;
    logic       mem_ack_i = 1'b0;
    logic       mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o;
    logic [1:0] pc_src_o, alu_src_b_o, alu_op_o;
    logic       alu_src_a_o, ext_op_o, reg_we_o, reg_dst_o, mem_to_reg_o, illegal_o;
    logic [3:0] state_o;

    multicycle_ctrl dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .mem_ack_i    (mem_ack_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .iord_o       (iord_o),
        .ir_we_o      (ir_we_o),
        .pc_we_o      (pc_we_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .ext_op_o     (ext_op_o),
        .reg_we_o     (reg_we_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks   = 0;
    int       failures = 0;

    // Field order: state, req, mem_we, iord, ir_we, pc_we, pc_src, a, b, alu_op,
    // ext_op, reg_we, reg_dst, mem_to_reg, illegal.
    function automatic logic [20:0] v(input logic [3:0] st, input logic req, mwe, iord, irwe, pcwe,
                                      input logic [1:0] pcsrc, input logic a, input logic [1:0] b,
                                      input logic [1:0] aop, input logic ext, rwe, rdst, m2r, ill);
        return {st, req, mwe, iord, irwe, pcwe, pcsrc, a, b, aop, ext, rwe, rdst, m2r, ill};
    endfunction

    function automatic logic [20:0] e_fetch(input logic ack);
        return v(4'd0, 1, 0, 0, ack, ack, 2'b00, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_decode(input logic ill);
        return v(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 1, 0, 0, 0, ill);
    endfunction
    function automatic logic [20:0] e_addr();
        return v(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_mem_rd();
        return v(4'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_wb_mem();
        return v(4'd4, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0, 1, 0);
    endfunction
    function automatic logic [20:0] e_mem_wr();
        return v(4'd5, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_exec_r();
        return v(4'd6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_exec_i(input logic ext);
        return v(4'd7, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b11, ext, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_wb_alu(input logic rdst);
        return v(4'd8, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, rdst, 0, 0);
    endfunction
    function automatic logic [20:0] e_branch(input logic pcwe);
        return v(4'd9, 0, 0, 0, 0, pcwe, 2'b01, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] e_jump();
        return v(4'd10, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%06h expected=%06h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected outputs for that cycle.
    task automatic step(input string name, input logic rst_n, input logic [5:0] op,
                        input logic ack, input logic zero, input logic [20:0] exp);
        sb_item_t it;
        rst_n_i   = rst_n;
        opcode_i  = op;
        mem_ack_i = ack;
        zero_i    = zero;
        it.name   = name;
        it.exp    = exp;
        sb_q.push_back(it);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            check(it.name, {state_o, mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
                            alu_src_a_o, alu_src_b_o, alu_op_o, ext_op_o, reg_we_o, reg_dst_o,
                            mem_to_reg_o, illegal_o}, it.exp);
        end
    end

    initial begin
        @(posedge clk_i);
        #1;
        step("reset_hold", 0, 6'h00, 1, 0, '0);

        // lw with zero-wait memory: 5 cycles
        step("lw_fetch",  1, 6'h23, 1, 0, e_fetch(1));
        step("lw_decode", 1, 6'h23, 1, 0, e_decode(0));
        step("lw_addr",   1, 6'h23, 1, 0, e_addr());
        step("lw_mem_rd", 1, 6'h23, 1, 0, e_mem_rd());
        step("lw_wb_mem", 1, 6'h23, 1, 0, e_wb_mem());

        // sw with three wait states in MEM_WR: 7 cycles
        step("sw_fetch",  1, 6'h2B, 1, 0, e_fetch(1));
        step("sw_decode", 1, 6'h2B, 0, 0, e_decode(0));
        step("sw_addr",   1, 6'h2B, 1, 0, e_addr());
        for (int i = 0; i < 3; i++)
            step("sw_mem_wr_wait", 1, 6'h2B, 0, 0, e_mem_wr());
        step("sw_mem_wr_ack", 1, 6'h2B, 1, 0, e_mem_wr());

        // branches, all four zero/opcode combinations
        step("beq_fetch",  1, 6'h04, 1, 1, e_fetch(1));
        step("beq_decode", 1, 6'h04, 1, 1, e_decode(0));
        step("beq_taken",  1, 6'h04, 1, 1, e_branch(1));
        step("bne_fetch",  1, 6'h05, 1, 1, e_fetch(1));
        step("bne_decode", 1, 6'h05, 1, 1, e_decode(0));
        step("bne_not_taken", 1, 6'h05, 1, 1, e_branch(0));
        step("beq_fetch2", 1, 6'h04, 1, 0, e_fetch(1));
        step("beq_decode2", 1, 6'h04, 1, 0, e_decode(0));
        step("beq_not_taken", 1, 6'h04, 1, 0, e_branch(0));
        step("bne_fetch2", 1, 6'h05, 1, 0, e_fetch(1));
        step("bne_decode2", 1, 6'h05, 1, 0, e_decode(0));
        step("bne_taken",  1, 6'h05, 1, 0, e_branch(1));

        // R-type with one fetch wait state
        step("r_fetch_wait", 1, 6'h00, 0, 0, e_fetch(0));
        step("r_fetch",      1, 6'h00, 1, 0, e_fetch(1));
        step("r_decode",     1, 6'h00, 1, 0, e_decode(0));
        step("r_exec",       1, 6'h00, 1, 0, e_exec_r());
        step("r_wb",         1, 6'h00, 1, 0, e_wb_alu(1));

        // addi: sign-extended immediate, rt destination
        step("addi_fetch",  1, 6'h08, 1, 0, e_fetch(1));
        step("addi_decode", 1, 6'h08, 1, 0, e_decode(0));
        step("addi_exec",   1, 6'h08, 1, 0, e_exec_i(1));
        step("addi_wb",     1, 6'h08, 1, 0, e_wb_alu(0));

        // ori depends on the build option
        step("ori_fetch", 1, 6'h0D, 1, 0, e_fetch(1));
`ifdef MULTICYCLE_CTRL_LOGIC_IMM_EN
        step("ori_decode", 1, 6'h0D, 1, 0, e_decode(0));
        step("ori_exec",   1, 6'h0D, 1, 0, e_exec_i(0));
        step("ori_wb",     1, 6'h0D, 1, 0, e_wb_alu(0));
`else
        step("ori_decode_illegal", 1, 6'h0D, 1, 0, e_decode(1));
`endif

        // jump
        step("j_fetch",  1, 6'h02, 1, 0, e_fetch(1));
        step("j_decode", 1, 6'h02, 1, 0, e_decode(0));
        step("j_jump",   1, 6'h02, 1, 0, e_jump());

        // unsupported opcode: single illegal pulse, straight back to FETCH
        step("ill_fetch",  1, 6'h3F, 1, 0, e_fetch(1));
        step("ill_decode", 1, 6'h3F, 1, 0, e_decode(1));
        step("ill_refetch_wait", 1, 6'h3F, 0, 0, e_fetch(0));

        // reset asserted mid-MEM_RD while the memory stalls
        step("rst_lw_fetch",  1, 6'h23, 1, 0, e_fetch(1));
        step("rst_lw_decode", 1, 6'h23, 1, 0, e_decode(0));
        step("rst_lw_addr",   1, 6'h23, 1, 0, e_addr());
        step("rst_lw_mem_rd_wait", 1, 6'h23, 0, 0, e_mem_rd());
        step("rst_abort", 0, 6'h23, 0, 0, '0);
        step("rst_release_fetch", 1, 6'h23, 0, 0, e_fetch(0));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_i);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
